// File: rtl/jelly3_axi4l_sequencer.sv
// Table-driven AXI4-Lite master: replays WRITE/READ/POLL/END entries from a
// loadable command RAM, with masked polling, retry limit and response-error abort.
module jelly3_axi4l_sequencer #(
  parameter  int ADDR_BITS = 32,
  parameter  int DATA_BITS = 32,
  parameter  int DEPTH     = 64,
  parameter  int POLL_MAX  = 1024,
  localparam int PTR_BITS  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_we,
  input  logic [PTR_BITS-1:0]    cmd_addr,
  input  logic [1:0]             cmd_op,
  input  logic [ADDR_BITS-1:0]   cmd_araddr,
  input  logic [DATA_BITS-1:0]   cmd_data,
  input  logic [DATA_BITS-1:0]   cmd_mask,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [PTR_BITS-1:0]    err_index,
  output logic                   rd_valid,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic [ADDR_BITS-1:0]   m_axi4l_awaddr,
  output logic [2:0]             m_axi4l_awprot,
  output logic                   m_axi4l_awvalid,
  input  logic                   m_axi4l_awready,
  output logic [DATA_BITS-1:0]   m_axi4l_wdata,
  output logic [DATA_BITS/8-1:0] m_axi4l_wstrb,
  output logic                   m_axi4l_wvalid,
  input  logic                   m_axi4l_wready,
  input  logic [1:0]             m_axi4l_bresp,
  input  logic                   m_axi4l_bvalid,
  output logic                   m_axi4l_bready,
  output logic [ADDR_BITS-1:0]   m_axi4l_araddr,
  output logic [2:0]             m_axi4l_arprot,
  output logic                   m_axi4l_arvalid,
  input  logic                   m_axi4l_arready,
  input  logic [DATA_BITS-1:0]   m_axi4l_rdata,
  input  logic [1:0]             m_axi4l_rresp,
  input  logic                   m_axi4l_rvalid,
  output logic                   m_axi4l_rready
);

  localparam int ENT_BITS = 2 + ADDR_BITS + 2 * DATA_BITS;
  localparam int CNT_BITS = $clog2(POLL_MAX + 1);
  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_POLL  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_WADDR, ST_WRESP, ST_RADDR, ST_RDATA, ST_CHECK, ST_FINISH
  } state_t;

  state_t                r_state, w_state_next;
  logic [PTR_BITS-1:0]   r_ptr, w_ptr_next;
  logic [CNT_BITS-1:0]   r_poll_cnt, w_poll_cnt_next;
  logic                  r_busy, w_busy_next;
  logic                  r_done, w_done_next;
  logic                  r_error, w_error_next;
  logic [PTR_BITS-1:0]   r_err_index, w_err_index_next;
  logic                  r_rd_valid, w_rd_valid_next;
  logic [DATA_BITS-1:0]  r_rd_data, w_rd_data_next;
  logic                  r_awvalid, w_awvalid_next;
  logic                  r_wvalid, w_wvalid_next;
  logic                  r_bready, w_bready_next;
  logic                  r_arvalid, w_arvalid_next;
  logic                  r_rready, w_rready_next;

  logic [ENT_BITS-1:0]   r_mem [DEPTH];
  logic [ENT_BITS-1:0]   r_ent;
  logic [1:0]            w_ent_op;
  logic [ADDR_BITS-1:0]  w_ent_addr;
  logic [DATA_BITS-1:0]  w_ent_data;
  logic [DATA_BITS-1:0]  w_ent_mask;

  assign {w_ent_op, w_ent_addr, w_ent_data, w_ent_mask} = r_ent;

  // Read address follows the next pointer so the entry is ready while in FETCH
  // and stays stable for the whole command.
  always_ff @(posedge clk) begin
    if (cmd_we && !r_busy) begin
      r_mem[cmd_addr] <= {cmd_op, cmd_araddr, cmd_data, cmd_mask};
    end
    r_ent <= r_mem[w_ptr_next];
  end

  logic                  w_last;
  logic                  w_match;
  logic [CNT_BITS-1:0]   w_poll_inc;
  state_t                w_adv_state;
  logic [PTR_BITS-1:0]   w_adv_ptr;

  assign w_last      = (r_ptr == PTR_BITS'(DEPTH - 1));
  assign w_match     = ((r_rd_data & w_ent_mask) == (w_ent_data & w_ent_mask));
  assign w_poll_inc  = r_poll_cnt + CNT_BITS'(1);
  assign w_adv_state = w_last ? ST_FINISH : ST_FETCH;
  assign w_adv_ptr   = w_last ? r_ptr : r_ptr + PTR_BITS'(1);

  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_poll_cnt_next  = r_poll_cnt;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_error_next     = r_error;
    w_err_index_next = r_err_index;
    w_rd_valid_next  = 1'b0;
    w_rd_data_next   = r_rd_data;
    w_awvalid_next   = r_awvalid;
    w_wvalid_next    = r_wvalid;
    w_bready_next    = r_bready;
    w_arvalid_next   = r_arvalid;
    w_rready_next    = r_rready;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_ptr_next      = '0;
          w_poll_cnt_next = '0;
          w_error_next    = 1'b0;
          w_busy_next     = 1'b1;
          w_state_next    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        case (w_ent_op)
          OP_WRITE: begin
            w_awvalid_next = 1'b1;
            w_wvalid_next  = 1'b1;
            w_state_next   = ST_WADDR;
          end
          OP_READ, OP_POLL: begin
            w_arvalid_next = 1'b1;
            w_state_next   = ST_RADDR;
          end
          default: w_state_next = ST_FINISH;
        endcase
      end
      ST_WADDR: begin
        if (m_axi4l_awready) w_awvalid_next = 1'b0;
        if (m_axi4l_wready)  w_wvalid_next  = 1'b0;
        if ((!r_awvalid || m_axi4l_awready) && (!r_wvalid || m_axi4l_wready)) begin
          w_bready_next = 1'b1;
          w_state_next  = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (m_axi4l_bvalid) begin
          w_bready_next = 1'b0;
          if (m_axi4l_bresp != 2'b00) begin
            w_error_next     = 1'b1;
            w_err_index_next = r_ptr;
            w_state_next     = ST_FINISH;
          end else begin
            w_ptr_next   = w_adv_ptr;
            w_state_next = w_adv_state;
          end
        end
      end
      ST_RADDR: begin
        if (m_axi4l_arready) begin
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
          w_state_next   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (m_axi4l_rvalid) begin
          w_rready_next   = 1'b0;
          w_rd_data_next  = m_axi4l_rdata;
          w_rd_valid_next = 1'b1;
          if (m_axi4l_rresp != 2'b00) begin
            w_error_next     = 1'b1;
            w_err_index_next = r_ptr;
            w_state_next     = ST_FINISH;
          end else if (w_ent_op == OP_POLL) begin
            w_state_next = ST_CHECK;
          end else begin
            w_ptr_next   = w_adv_ptr;
            w_state_next = w_adv_state;
          end
        end
      end
      ST_CHECK: begin
        if (w_match) begin
          w_poll_cnt_next = '0;
          w_ptr_next      = w_adv_ptr;
          w_state_next    = w_adv_state;
        end else if (w_poll_inc == CNT_BITS'(POLL_MAX)) begin
          w_error_next     = 1'b1;
          w_err_index_next = r_ptr;
          w_state_next     = ST_FINISH;
        end else begin
          w_poll_cnt_next = w_poll_inc;
          w_arvalid_next  = 1'b1;
          w_state_next    = ST_RADDR;
        end
      end
      ST_FINISH: begin
        w_busy_next  = 1'b0;
        w_done_next  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_poll_cnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_poll_cnt  <= w_poll_cnt_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_error     <= w_error_next;
      r_err_index <= w_err_index_next;
      r_rd_valid  <= w_rd_valid_next;
      r_rd_data   <= w_rd_data_next;
      r_awvalid   <= w_awvalid_next;
      r_wvalid    <= w_wvalid_next;
      r_bready    <= w_bready_next;
      r_arvalid   <= w_arvalid_next;
      r_rready    <= w_rready_next;
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;
  assign err_index       = r_err_index;
  assign rd_valid        = r_rd_valid;
  assign rd_data         = r_rd_data;
  assign m_axi4l_awaddr  = w_ent_addr;
  assign m_axi4l_awprot  = 3'b000;
  assign m_axi4l_awvalid = r_awvalid;
  assign m_axi4l_wdata   = w_ent_data;
  assign m_axi4l_wstrb   = '1;
  assign m_axi4l_wvalid  = r_wvalid;
  assign m_axi4l_bready  = r_bready;
  assign m_axi4l_araddr  = w_ent_addr;
  assign m_axi4l_arprot  = 3'b000;
  assign m_axi4l_arvalid = r_arvalid;
  assign m_axi4l_rready  = r_rready;

endmodule

// File: tb/tb_jelly3_axi4l_sequencer.sv
// Bench for jelly3_axi4l_sequencer: AXI4-Lite slave with programmable waits,
// command-list reference model, directed case table and randomized tables.
module tb_jelly3_axi4l_sequencer;

  localparam int AB = 32;
  localparam int DB = 32;
  localparam int DEP = 8;
  localparam int PB = 3;
  localparam int PMAX = 4;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
  } cmd_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    int first; int n; int aw_f; int w_f; int scr_k;
    int e_wr; int e_rd; int e_err; int e_idx;
  } case_t;

  logic clk = 1'b0;
  logic reset, cmd_we, start;
  logic [PB-1:0] cmd_addr;
  logic [1:0] cmd_op;
  logic [AB-1:0] cmd_araddr;
  logic [DB-1:0] cmd_data, cmd_mask;
  logic busy, done, error, rd_valid;
  logic [PB-1:0] err_index;
  logic [DB-1:0] rd_data;
  logic [AB-1:0] m_axi4l_awaddr, m_axi4l_araddr;
  logic [2:0] m_axi4l_awprot, m_axi4l_arprot;
  logic m_axi4l_awvalid, m_axi4l_wvalid, m_axi4l_bready, m_axi4l_arvalid, m_axi4l_rready;
  logic [DB-1:0] m_axi4l_wdata;
  logic [DB/8-1:0] m_axi4l_wstrb;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic [DB-1:0] s_rdata;

  always #5 clk = ~clk;

  jelly3_axi4l_sequencer #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .DEPTH(DEP), .POLL_MAX(PMAX)
  ) dut (
    .clk(clk), .reset(reset), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_op(cmd_op),
    .cmd_araddr(cmd_araddr), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .start(start),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .m_axi4l_awaddr(m_axi4l_awaddr), .m_axi4l_awprot(m_axi4l_awprot),
    .m_axi4l_awvalid(m_axi4l_awvalid), .m_axi4l_awready(s_awready),
    .m_axi4l_wdata(m_axi4l_wdata), .m_axi4l_wstrb(m_axi4l_wstrb),
    .m_axi4l_wvalid(m_axi4l_wvalid), .m_axi4l_wready(s_wready),
    .m_axi4l_bresp(s_bresp), .m_axi4l_bvalid(s_bvalid), .m_axi4l_bready(m_axi4l_bready),
    .m_axi4l_araddr(m_axi4l_araddr), .m_axi4l_arprot(m_axi4l_arprot),
    .m_axi4l_arvalid(m_axi4l_arvalid), .m_axi4l_arready(s_arready),
    .m_axi4l_rdata(s_rdata), .m_axi4l_rresp(s_rresp), .m_axi4l_rvalid(s_rvalid),
    .m_axi4l_rready(m_axi4l_rready)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int aw_fix, w_fix, b_fix, ar_fix, r_fix;
  int aw_lat, w_lat, b_lat, ar_lat, r_lat;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_got, w_got, ar_got;
  logic [31:0] aw_a, w_d, ar_a;
  int n_aw, n_w, n_dup, n_done, first_v, start_cyc;
  logic busy_at_done;
  logic p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [31:0] mem [64];
  logic [31:0] scr [$];
  txn_t obs [$];
  logic [31:0] rdq [$];
  cmd_t tbl [DEP];
  cmd_t dcmd [22];
  case_t dcase [7];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input int f);
    return (f >= 0) ? f : int'($urandom_range(0, 3));
  endfunction

  function automatic cmd_t mk(input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] m);
    cmd_t c;
    c.op = op; c.addr = a; c.data = d; c.mask = m;
    return c;
  endfunction

  // One clock: finish handshakes taken at the last rising edge, then decide the
  // slave drive for the next edge and sample the DUT.
  task automatic tick();
    txn_t t;
    @(negedge clk);
    cyc++;
    if (reset) begin
      aw_got = 0; w_got = 0; ar_got = 0;
      s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (p_awvalid && s_awready) begin aw_got = 1; aw_a = p_awaddr; n_aw++; end
      if (p_wvalid && s_wready) begin w_got = 1; w_d = p_wdata; n_w++; end
      if (s_bvalid && p_bready) begin
        t.wr = 1'b1; t.addr = aw_a; t.data = w_d;
        obs.push_back(t);
        $display("[TB] cyc %0d write addr=%h data=%h bresp=%0d", cyc, aw_a, w_d, s_bresp);
        if (!aw_a[11]) mem[aw_a[7:2]] = w_d;
        aw_got = 0; w_got = 0; s_bvalid = 0;
      end
      if (p_arvalid && s_arready) begin ar_got = 1; ar_a = p_araddr; end
      if (s_rvalid && p_rready) begin
        t.wr = 1'b0; t.addr = ar_a; t.data = s_rdata;
        obs.push_back(t);
        $display("[TB] cyc %0d read  addr=%h data=%h rresp=%0d", cyc, ar_a, s_rdata, s_rresp);
        ar_got = 0; s_rvalid = 0;
      end
      s_awready = 0;
      if (m_axi4l_awvalid && aw_got) n_dup++;
      else if (m_axi4l_awvalid) begin
        if (aw_cnt >= aw_lat) begin s_awready = 1; aw_cnt = 0; aw_lat = pick(aw_fix); end
        else aw_cnt++;
      end
      s_wready = 0;
      if (m_axi4l_wvalid && w_got) n_dup++;
      else if (m_axi4l_wvalid) begin
        if (w_cnt >= w_lat) begin s_wready = 1; w_cnt = 0; w_lat = pick(w_fix); end
        else w_cnt++;
      end
      if (aw_got && w_got && !s_bvalid) begin
        if (b_cnt >= b_lat) begin
          s_bvalid = 1; s_bresp = aw_a[11] ? 2'b10 : 2'b00; b_cnt = 0; b_lat = pick(b_fix);
        end else b_cnt++;
      end
      s_arready = 0;
      if (m_axi4l_arvalid && ar_got) n_dup++;
      else if (m_axi4l_arvalid) begin
        if (ar_cnt >= ar_lat) begin s_arready = 1; ar_cnt = 0; ar_lat = pick(ar_fix); end
        else ar_cnt++;
      end
      if (ar_got && !s_rvalid) begin
        if (r_cnt >= r_lat) begin
          s_rvalid = 1;
          if (scr.size() > 0) s_rdata = scr.pop_front();
          else s_rdata = mem[ar_a[7:2]];
          s_rresp = ar_a[11] ? 2'b10 : 2'b00;
          r_cnt = 0; r_lat = pick(r_fix);
        end else r_cnt++;
      end
    end
    if (rd_valid) rdq.push_back(rd_data);
    if (done) begin n_done++; busy_at_done = busy; end
    if (first_v < 0 && (m_axi4l_awvalid || m_axi4l_arvalid)) first_v = cyc - start_cyc;
    p_awvalid = m_axi4l_awvalid; p_awaddr = m_axi4l_awaddr;
    p_wvalid = m_axi4l_wvalid; p_wdata = m_axi4l_wdata;
    p_bready = m_axi4l_bready;
    p_arvalid = m_axi4l_arvalid; p_araddr = m_axi4l_araddr;
    p_rready = m_axi4l_rready;
  endtask

  task automatic load_cmd(input int idx, input cmd_t c);
    cmd_we = 1; cmd_addr = PB'(idx); cmd_op = c.op;
    cmd_araddr = c.addr; cmd_data = c.data; cmd_mask = c.mask;
    tick();
    cmd_we = 0;
    tbl[idx] = c;
  endtask

  task automatic clear_run();
    obs.delete(); rdq.delete();
    n_aw = 0; n_w = 0; n_dup = 0; n_done = 0; first_v = -1; busy_at_done = 1'bx;
    aw_lat = pick(aw_fix); w_lat = pick(w_fix); b_lat = pick(b_fix);
    ar_lat = pick(ar_fix); r_lat = pick(r_fix);
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
  endtask

  // Reference: walk the command list as a sequence of bus accesses.
  task automatic run_case(input string nm, input int e_wr, input int e_rd,
                          input int e_err, input int e_idx);
    txn_t m_obs [$];
    logic [31:0] m_rd [$];
    logic [31:0] mm [64];
    logic [31:0] ms [$];
    txn_t t;
    cmd_t c;
    logic [31:0] v;
    int ptr, tries, m_wr, o_wr;
    bit stop, m_err, ok;
    int m_idx;
    ms = scr;
    for (int i = 0; i < 64; i++) begin mm[i] = '0; mem[i] = '0; end
    ptr = 0; stop = 0; m_err = 0; m_idx = 0; m_wr = 0;
    while (!stop) begin
      c = tbl[ptr];
      if (c.op == 2'd0) begin
        t.wr = 1; t.addr = c.addr; t.data = c.data; m_obs.push_back(t); m_wr++;
        if (c.addr[11]) begin m_err = 1; m_idx = ptr; stop = 1; end
        else mm[c.addr[7:2]] = c.data;
      end else if (c.op == 2'd3) begin
        stop = 1;
      end else begin
        tries = 0; ok = 0;
        while (!ok && !stop) begin
          if (ms.size() > 0) v = ms.pop_front(); else v = mm[c.addr[7:2]];
          t.wr = 0; t.addr = c.addr; t.data = v; m_obs.push_back(t); m_rd.push_back(v);
          tries++;
          if (c.addr[11]) begin m_err = 1; m_idx = ptr; stop = 1; end
          else if (c.op == 2'd1 || ((v & c.mask) == (c.data & c.mask))) ok = 1;
          else if (tries == PMAX) begin m_err = 1; m_idx = ptr; stop = 1; end
        end
      end
      if (!stop) begin
        if (ptr == DEP - 1) stop = 1;
        else ptr++;
      end
    end

    clear_run();
    start_cyc = cyc; start = 1; tick(); start = 0;
    for (int k = 0; k < 3000 && n_done == 0; k++) tick();
    repeat (3) tick();

    chk({nm, " done_pulses"}, 96'(n_done), 96'(1));
    chk({nm, " busy_at_done"}, 96'(busy_at_done), 96'(0));
    chk({nm, " busy_after"}, 96'(busy), 96'(0));
    chk({nm, " error"}, 96'(error), 96'(m_err));
    if (m_err) chk({nm, " err_index"}, 96'(err_index), 96'(m_idx));
    chk({nm, " txn_count"}, 96'(obs.size()), 96'(m_obs.size()));
    for (int i = 0; i < obs.size() && i < m_obs.size(); i++)
      chk($sformatf("%s txn%0d", nm, i), 96'(obs[i]), 96'(m_obs[i]));
    chk({nm, " rd_valid_count"}, 96'(rdq.size()), 96'(m_rd.size()));
    for (int i = 0; i < rdq.size() && i < m_rd.size(); i++)
      chk($sformatf("%s rd_data%0d", nm, i), 96'(rdq[i]), 96'(m_rd[i]));
    chk({nm, " aw_hs"}, 96'(n_aw), 96'(m_wr));
    chk({nm, " w_hs"}, 96'(n_w), 96'(m_wr));
    chk({nm, " dup_valid"}, 96'(n_dup), 96'(0));
    chk({nm, " first_valid_cycle"}, 96'(first_v), 96'((m_obs.size() > 0) ? 2 : -1));
    o_wr = 0;
    foreach (obs[i]) if (obs[i].wr) o_wr++;
    if (e_wr >= 0) chk({nm, " writes"}, 96'(o_wr), 96'(e_wr));
    if (e_rd >= 0) chk({nm, " reads"}, 96'(rdq.size()), 96'(e_rd));
    if (e_err >= 0) chk({nm, " err_flag"}, 96'(error), 96'(e_err));
    if (e_idx >= 0) chk({nm, " err_idx"}, 96'(err_index), 96'(e_idx));
  endtask

  initial begin
    reset = 1; cmd_we = 0; start = 0; cmd_addr = '0; cmd_op = '0;
    cmd_araddr = '0; cmd_data = '0; cmd_mask = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
    s_arready = 0; s_rvalid = 0; s_rresp = '0; s_rdata = '0;
    aw_fix = 0; w_fix = 0; b_fix = 0; ar_fix = 0; r_fix = 0;
    p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    clear_run();
    repeat (4) tick();
    reset = 0;
    tick();
    chk("rst busy", 96'(busy), 96'(0));
    chk("rst done", 96'(done), 96'(0));
    chk("rst error", 96'(error), 96'(0));
    chk("rst err_index", 96'(err_index), 96'(0));
    chk("rst rd_valid", 96'(rd_valid), 96'(0));
    chk("rst rd_data", 96'(rd_data), 96'(0));
    chk("rst valids", 96'({m_axi4l_awvalid, m_axi4l_wvalid, m_axi4l_arvalid}), 96'(0));
    chk("rst readies", 96'({m_axi4l_bready, m_axi4l_rready}), 96'(0));

    dcmd[0]  = mk(2'd0, 32'h10, 32'hA5, 32'h0);
    dcmd[1]  = mk(2'd3, 32'h0, 32'h0, 32'h0);
    dcmd[2]  = mk(2'd2, 32'h20, 32'h1, 32'h1);
    dcmd[3]  = mk(2'd3, 32'h0, 32'h0, 32'h0);
    dcmd[4]  = mk(2'd2, 32'h24, 32'h1, 32'h1);
    dcmd[5]  = mk(2'd3, 32'h0, 32'h0, 32'h0);
    dcmd[6]  = mk(2'd0, 32'h30, 32'h1, 32'h0);
    dcmd[7]  = mk(2'd0, 32'h34, 32'h2, 32'h0);
    dcmd[8]  = mk(2'd1, 32'h804, 32'h0, 32'h0);
    dcmd[9]  = mk(2'd0, 32'h38, 32'h3, 32'h0);
    dcmd[10] = mk(2'd3, 32'h0, 32'h0, 32'h0);
    dcmd[11] = mk(2'd0, 32'h800, 32'h5, 32'h0);
    dcmd[12] = mk(2'd0, 32'h10, 32'h6, 32'h0);
    dcmd[13] = mk(2'd3, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) dcmd[14 + i] = mk(2'd1, 32'h10 + 32'(4 * i), 32'h0, 32'h0);

    //            first n aw w scr wr rd err idx
    dcase[0] = '{0,  2, 0, 0, 0, 1, 0, 0, -1};
    dcase[1] = '{0,  2, 0, 3, 0, 1, 0, 0, -1};
    dcase[2] = '{2,  2, 0, 0, 1, 0, 3, 0, -1};
    dcase[3] = '{4,  2, 0, 0, 0, 0, 4, 1, 0};
    dcase[4] = '{6,  5, 0, 0, 0, 2, 1, 1, 2};
    dcase[5] = '{11, 3, 0, 0, 0, 1, 0, 1, 0};
    dcase[6] = '{14, 8, 0, 0, 0, 0, 8, 0, -1};

    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < dcase[c].n; i++) load_cmd(i, dcmd[dcase[c].first + i]);
      aw_fix = dcase[c].aw_f; w_fix = dcase[c].w_f; b_fix = 0; ar_fix = 0; r_fix = 0;
      scr.delete();
      if (dcase[c].scr_k == 1) begin scr.push_back(32'h0); scr.push_back(32'h0); scr.push_back(32'h1); end
      run_case($sformatf("case%0d", c), dcase[c].e_wr, dcase[c].e_rd, dcase[c].e_err, dcase[c].e_idx);
    end

    // Reset while a write address is pending, then replay the same table.
    load_cmd(0, mk(2'd0, 32'h40, 32'h7, 32'h0));
    load_cmd(1, mk(2'd3, 32'h0, 32'h0, 32'h0));
    aw_fix = 10; w_fix = 10; scr.delete();
    clear_run();
    start_cyc = cyc; start = 1; tick(); start = 0;
    for (int k = 0; k < 10 && !m_axi4l_awvalid; k++) tick();
    chk("rstmid awvalid_seen", 96'(m_axi4l_awvalid), 96'(1));
    reset = 1; tick();
    chk("rstmid awvalid", 96'(m_axi4l_awvalid), 96'(0));
    chk("rstmid wvalid", 96'(m_axi4l_wvalid), 96'(0));
    chk("rstmid busy", 96'(busy), 96'(0));
    reset = 0; tick(); tick();
    chk("rstmid no_done", 96'(n_done), 96'(0));
    chk("rstmid no_txn", 96'(obs.size()), 96'(0));
    aw_fix = 0; w_fix = 0;
    run_case("replay", 1, 0, 0, -1);

    for (int r = 0; r < 25; r++) begin
      int pr;
      for (int i = 0; i < DEP; i++) begin
        cmd_t c;
        pr = int'($urandom_range(0, 99));
        c.op = (pr < 40) ? 2'd0 : (pr < 70) ? 2'd1 : (pr < 90) ? 2'd2 : 2'd3;
        c.addr = ($urandom_range(0, 14) == 0) ? 32'h800 : 32'h10 + 32'(4 * $urandom_range(0, 7));
        c.data = $urandom;
        c.mask = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'h1;
        load_cmd(i, c);
      end
      scr.delete();
      repeat ($urandom_range(0, 4)) scr.push_back(32'($urandom_range(0, 1)));
      aw_fix = -1; w_fix = -1; b_fix = -1; ar_fix = -1; r_fix = -1;
      run_case($sformatf("rand%0d", r), -1, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
